// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, arbiter state type and index helper for the cost-table arbiter
package jam_pkg;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_pick_onehot.sv
// rr_pick_onehot: first set request at or after the pointer, as a one-hot grant
module rr_pick_onehot #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);
  logic [N-1:0] w_rot;
  logic [N-1:0] w_sel;
  // rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign w_sel = w_rot & (~w_rot + N'(1));
  assign o_gnt = N'(({w_sel, w_sel} << i_ptr) >> N);
endmodule

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin sharing of the cost-table read port between search engines,
// with locked row-scan bursts and id-tagged return of each read.
module jam_cost_arbiter #(
  parameter int NREQ      = 2,
  parameter int IDX_W     = jam_pkg::IDX_W,
  parameter int COST_W    = jam_pkg::COST_W,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*IDX_W-1:0] req_w,
  input  logic [NREQ*IDX_W-1:0] req_j,
  output logic [NREQ-1:0]       gnt,
  output logic [IDX_W-1:0]      W,
  output logic [IDX_W-1:0]      J,
  input  logic [COST_W-1:0]     Cost,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [COST_W-1:0]     rsp_cost,
  output logic                  busy
);
  import jam_pkg::*;
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t                     r_state, w_state_nxt;
  logic [PW-1:0]                  r_rr, w_rr_nxt, r_owner, w_owner_nxt;
  logic [PW-1:0]                  w_pick_idx, w_idx;
  logic [BW-1:0]                  r_burst, w_burst_nxt;
  logic [NREQ-1:0]                w_pick, w_gnt;
  logic [IDX_W-1:0]               r_w, r_j;
  logic [ROM_LAT-1:0]             r_tag_v;
  logic [ROM_LAT-1:0][PW-1:0]     r_tag_id;
  logic [NREQ-1:0]                r_rsp_valid;
  logic [COST_W-1:0]              r_rsp_cost;

  rr_pick_onehot #(.N(NREQ), .PW(PW)) u_pick (
    .i_req(req),
    .i_ptr(r_rr),
    .o_gnt(w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) if (w_pick[i]) w_pick_idx = PW'(i);
  end

  assign w_idx = (r_state == ARB) ? w_pick_idx : r_owner;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst;
    w_gnt       = '0;
    if (r_state == ARB) begin
      w_gnt = w_pick;
      if (|w_pick) begin
        w_rr_nxt = PW'(wrap_inc(int'(w_pick_idx), NREQ));
        if (lock[w_pick_idx]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_pick_idx;
          w_burst_nxt = BW'(1);
        end
      end
    end else begin
      w_gnt       = req[r_owner] ? NREQ'(1) << r_owner : '0;
      w_burst_nxt = req[r_owner] ? r_burst + BW'(1) : r_burst;
      // released by dropping lock (with or without a final grant) or by exhausting the burst
      if (!lock[r_owner] || (req[r_owner] && int'(r_burst) + 1 >= MAX_BURST)) begin
        w_state_nxt = ARB;
        w_rr_nxt    = PW'(wrap_inc(int'(r_owner), NREQ));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ARB;
      r_rr        <= '0;
      r_owner     <= '0;
      r_burst     <= '0;
      r_w         <= '0;
      r_j         <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_cost  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_owner <= w_owner_nxt;
      r_burst <= w_burst_nxt;
      if (|w_gnt) begin
        r_w <= req_w[w_idx*IDX_W +: IDX_W];
        r_j <= req_j[w_idx*IDX_W +: IDX_W];
      end
      for (int s = ROM_LAT - 1; s > 0; s--) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_tag_v[0]  <= |w_gnt;
      r_tag_id[0] <= w_idx;
      r_rsp_valid <= r_tag_v[ROM_LAT-1] ? NREQ'(1) << r_tag_id[ROM_LAT-1] : '0;
      if (r_tag_v[ROM_LAT-1]) r_rsp_cost <= Cost;
    end
  end

  assign gnt       = w_gnt;
  assign W         = r_w;
  assign J         = r_j;
  assign rsp_valid = r_rsp_valid;
  assign rsp_cost  = r_rsp_cost;
  assign busy      = (|r_tag_v) || (r_state == LOCKED);
endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: randomized scoreboard bench with a behavioural arbiter and cost-table model
module tb_jam_cost_arbiter;
  localparam int N    = 3;
  localparam int IW   = 3;
  localparam int CW   = 7;
  localparam int LAT  = 2;
  localparam int MAXB = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  req = '0, lock = '0, gnt, rsp_valid;
  logic [N*IW-1:0] req_w = '0, req_j = '0;
  logic [IW-1:0] W, J;
  logic [CW-1:0] Cost, rsp_cost;
  logic          busy;

  always #5 CLK = ~CLK;

  jam_cost_arbiter #(.NREQ(N), .IDX_W(IW), .COST_W(CW), .ROM_LAT(LAT), .MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .lock(lock), .req_w(req_w), .req_j(req_j),
    .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rsp_valid(rsp_valid), .rsp_cost(rsp_cost), .busy(busy)
  );

  function automatic logic [CW-1:0] tbl(input logic [IW-1:0] w, input logic [IW-1:0] j);
    return CW'(int'(w) * 11 + int'(j) * 5 + 3);
  endfunction

  // cost table: data for the address presented LAT edges earlier
  logic [CW-1:0] rom_d [LAT];
  always @(posedge CLK) begin
    rom_d[0] <= tbl(W, J);
    for (int s = 1; s < LAT; s++) rom_d[s] <= rom_d[s-1];
  end
  generate
    if (LAT == 1) begin : g_comb
      assign Cost = tbl(W, J);
    end else begin : g_reg
      assign Cost = rom_d[LAT-2];
    end
  endgenerate

  typedef struct {int id; logic [CW-1:0] cost; int due;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc = 0;
  int m_rr = 0, m_owner = 0, m_burst = 0;
  bit m_locked = 0;
  logic [IW-1:0] m_w = '0, m_j = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rsp_valid != '0) begin
      if (q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        mon_e = q.pop_front();
        check("rsp_id", 32'(rsp_valid), 32'(1) << mon_e.id);
        check("rsp_cost", 32'(rsp_cost), 32'(mon_e.cost));
        check("rsp_cycle", cyc, mon_e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("rsp_missing", 0, 1);
      void'(q.pop_front());
    end
  end

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_owner = 0; m_burst = 0; m_locked = 0; m_w = '0; m_j = '0;
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lk,
                      input logic [N*IW-1:0] wv, input logic [N*IW-1:0] jv);
    int g = -1;
    bit b = 0;
    @(negedge CLK);
    req = rq; lock = lk; req_w = wv; req_j = jv;
    #1;
    foreach (q[k]) if (q[k].due > cyc) b = 1;
    check("busy", 32'(busy), 32'(b | m_locked));
    check("W", 32'(W), 32'(m_w));
    check("J", 32'(J), 32'(m_j));
    if (!m_locked) begin
      for (int k = 0; k < N; k++) if (g < 0 && rq[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (lk[g]) begin m_locked = 1; m_owner = g; m_burst = 1; end
      end
    end else if (rq[m_owner]) begin
      g = m_owner;
      m_burst++;
      if (!lk[g] || m_burst >= MAXB) begin m_locked = 0; m_rr = (g + 1) % N; end
    end else if (!lk[m_owner]) begin
      m_locked = 0; m_rr = (m_owner + 1) % N;
    end
    check("gnt", 32'(gnt), g < 0 ? 0 : 32'(1) << g);
    if (g >= 0) begin
      m_w = wv[g*IW +: IW];
      m_j = jv[g*IW +: IW];
      q.push_back('{id: g, cost: tbl(m_w, m_j), due: cyc + LAT + 1});
    end
  endtask

  task automatic rstep(input logic [N-1:0] rq, input logic [N-1:0] lk);
    step(rq, lk, (N*IW)'($urandom), (N*IW)'($urandom));
  endtask

  logic [N*IW-1:0] tw, tj;
  logic [N-1:0] rq, lk;

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    check("rst_W", 32'(W), 0);
    check("rst_J", 32'(J), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_cost", 32'(rsp_cost), 0);
    check("rst_busy", 32'(busy), 0);
    RST_N = 1'b1;
    // single engine read with known address
    tw = (N*IW)'($urandom); tj = (N*IW)'($urandom);
    tw[IW-1:0] = 3'd3; tj[IW-1:0] = 3'd5;
    step(3'b001, '0, tw, tj);
    repeat (4) rstep('0, '0);
    // round-robin alternation
    repeat (6) rstep(3'b011, '0);
    repeat (6) rstep(3'b111, '0);
    // forced release after MAX_BURST locked grants
    rstep(3'b010, 3'b010);
    repeat (12) rstep(3'b011, 3'b010);
    // owner drops lock on its third grant
    rstep(3'b010, 3'b010);
    rstep(3'b011, 3'b010);
    rstep(3'b011, 3'b001);
    rstep(3'b011, '0);
    // owner idles while locked, then drops both req and lock
    rstep(3'b100, 3'b100);
    repeat (3) rstep(3'b011, 3'b100);
    rstep(3'b011, '0);
    repeat (4) rstep('0, '0);
    // reset one cycle after a grant drops the in-flight read
    rstep(3'b001, '0);
    @(negedge CLK);
    RST_N = 1'b0; req = '0; lock = '0;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_W", 32'(W), 0);
    check("midrst_J", 32'(J), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) rstep('0, '0);
    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom);
      case ((i / 500) % 3)
        0: lk = ($urandom_range(7) == 0) ? N'($urandom) : '0;
        1: lk = N'($urandom);
        default: begin
          rq = ($urandom_range(3) == 0) ? N'($urandom) : '1;
          lk = ($urandom_range(15) == 0) ? N'($urandom) : '1;
        end
      endcase
      rstep(rq, lk);
    end
    repeat (20) rstep('0, '0);
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
